// File: rtl/input_buffer_cfg_ctrl.sv
// Run-time FFT-size change sequencer for the channelizer input buffer: gates the
// sample stream, drains, resets the buffer with the new size, settles, reopens.
module input_buffer_cfg_ctrl #(
  parameter int unsigned DEF_FFT_SIZE  = 256,
  parameter int unsigned MIN_FFT_SIZE  = 8,
  parameter int unsigned MAX_FFT_SIZE  = 512,
  parameter int unsigned QUIET_CYCLES  = 16,
  parameter int unsigned DRAIN_TIMEOUT = 2048,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       sync_reset_n,
  input  logic [9:0] cfg_fft_size,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       cfg_err,
  input  logic       up_tvalid,
  output logic       up_tready,
  output logic       buf_tvalid,
  input  logic       buf_tready,
  input  logic       buf_valid_out,
  output logic [9:0] fft_size,
  output logic       buf_reset,
  output logic       busy,
  output logic       drain_to
);

  localparam int unsigned SW = 10;
  localparam int unsigned QW = (QUIET_CYCLES  > 1) ? $clog2(QUIET_CYCLES)  : 1;
  localparam int unsigned TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned RW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   rst_q, rst_d;
  logic [CW-1:0]   settle_q, settle_d;
  logic [SW-1:0]   pending_q, pending_d;
  logic [SW-1:0]   fft_size_d;
  logic            buf_reset_d, cfg_ready_d, cfg_err_d, busy_d, drain_to_d;
  logic            size_pow2, size_legal;

  assign size_pow2  = (cfg_fft_size != '0) &&
                      ((cfg_fft_size & (cfg_fft_size - SW'(1))) == '0);
  assign size_legal = size_pow2 &&
                      (cfg_fft_size >= SW'(MIN_FFT_SIZE)) &&
                      (cfg_fft_size <= SW'(MAX_FFT_SIZE));

  // Stream gating is combinational so a beat is never split across a state change.
  assign buf_tvalid = (state_q == ST_RUN) & up_tvalid;
  assign up_tready  = (state_q == ST_RUN) & buf_tready;

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      state_q   <= ST_RESET;
      quiet_q   <= '0;
      tmo_q     <= '0;
      rst_q     <= '0;
      settle_q  <= '0;
      pending_q <= SW'(DEF_FFT_SIZE);
      fft_size  <= SW'(DEF_FFT_SIZE);
      buf_reset <= 1'b1;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b1;
      drain_to  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quiet_q   <= quiet_d;
      tmo_q     <= tmo_d;
      rst_q     <= rst_d;
      settle_q  <= settle_d;
      pending_q <= pending_d;
      fft_size  <= fft_size_d;
      buf_reset <= buf_reset_d;
      cfg_ready <= cfg_ready_d;
      cfg_err   <= cfg_err_d;
      busy      <= busy_d;
      drain_to  <= drain_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    quiet_d     = quiet_q;
    tmo_d       = tmo_q;
    rst_d       = rst_q;
    settle_d    = settle_q;
    pending_d   = pending_q;
    fft_size_d  = fft_size;
    buf_reset_d = buf_reset;
    cfg_err_d   = 1'b0;
    drain_to_d  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (cfg_valid && cfg_ready) begin
          if (!size_legal) begin
            cfg_err_d = 1'b1;
          end else if (cfg_fft_size != fft_size) begin
            pending_d = cfg_fft_size;
            quiet_d   = '0;
            tmo_d     = '0;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        tmo_d   = tmo_q + TW'(1);
        quiet_d = buf_valid_out ? '0 : quiet_q + QW'(1);
        // Quiet takes priority over timeout when both land on the same cycle.
        if (!buf_valid_out && (quiet_q == QW'(QUIET_CYCLES - 1))) begin
          state_d     = ST_RESET;
          rst_d       = '0;
          fft_size_d  = pending_q;
          buf_reset_d = 1'b1;
        end else if (tmo_q == TW'(DRAIN_TIMEOUT - 1)) begin
          state_d     = ST_RESET;
          rst_d       = '0;
          fft_size_d  = pending_q;
          buf_reset_d = 1'b1;
          drain_to_d  = 1'b1;
        end
      end
      ST_RESET: begin
        rst_d = rst_q + RW'(1);
        if (rst_q == RW'(RST_CYCLES - 1)) begin
          state_d     = ST_SETTLE;
          settle_d    = '0;
          buf_reset_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + CW'(1);
        if (settle_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    cfg_ready_d = (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
  end

endmodule
